// File: rtl/sensor_frame_pkg.sv
// Shared types and helpers for the sensor frame aggregator.
//   state_e      : aggregator FSM states
//   frame_width  : width of the framed output word {seq, dirty_mask, channels}
//   popcount8    : number of set bits in an up-to-8-bit channel mask
package sensor_frame_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int frame_width(input int num_ch, input int ch_w, input int seq_w);
    return seq_w + num_ch + num_ch * ch_w;
  endfunction

  function automatic logic [3:0] popcount8(input logic [MAX_CH-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_CH; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/sensor_ch_slot.sv
// One sensor channel: shadow register holding the latest reading plus a
// dirty flag marking it as not yet framed.
//   clk, rst_n  : clock, async active-low reset
//   capture_i   : update strobe, loads data_i and sets dirty
//   clear_i     : frame snapshot taken this cycle, clears dirty
//   data_i      : incoming reading
//   shadow_o    : latest reading
//   dirty_o     : reading not yet sent
//   overwrite_o : an unsent reading is being replaced this cycle
module sensor_ch_slot
  import sensor_frame_pkg::*;
#(
  parameter int CH_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture_i,
  input  logic            clear_i,
  input  logic [CH_W-1:0] data_i,
  output logic [CH_W-1:0] shadow_o,
  output logic            dirty_o,
  output logic            overwrite_o
);

  logic [CH_W-1:0] shadow_q;
  logic            dirty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      dirty_q  <= 1'b0;
    end else begin
      if (capture_i) shadow_q <= data_i;
      // A capture coinciding with a snapshot keeps the channel dirty: the
      // new value is not part of the frame being taken.
      if (capture_i)    dirty_q <= 1'b1;
      else if (clear_i) dirty_q <= 1'b0;
    end
  end

  // On a snapshot cycle the current shadow goes into the frame, so the
  // incoming value replaces nothing unsent.
  assign overwrite_o = capture_i & dirty_q & ~clear_i;
  assign shadow_o    = shadow_q;
  assign dirty_o     = dirty_q;

endmodule

// File: rtl/sensor_frame_agg.sv
// N-channel sensor aggregator: captures per-channel readings into shadow
// registers, frames {seq, dirty_mask, ch[N-1]..ch[0]} for a ready/valid
// consumer, enforces a hold-off after each accepted frame and counts
// overwritten unsent readings.
//   clk, rst_n  : clock, async active-low reset
//   ch_data     : channel i at [i*CH_W +: CH_W]
//   ch_valid    : per-channel update strobe
//   frame_data  : framed word, stable while frame_valid
//   frame_valid : frame available
//   frame_ready : consumer accepts frame
//   drop_cnt    : saturating count of overwritten unsent updates
//   busy        : FSM in SEND or HOLD
module sensor_frame_agg
  import sensor_frame_pkg::*;
#(
  parameter int  NUM_CH  = 2,
  parameter int  CH_W    = 24,
  parameter int  SEQ_W   = 8,
  parameter int  HOLDOFF = 100,
  parameter int  DROP_W  = 16,
  localparam int FRAME_W = frame_width(NUM_CH, CH_W, SEQ_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]      ch_valid,
  output logic [FRAME_W-1:0]     frame_data,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   busy
);

  localparam int HW = $clog2(HOLDOFF + 2);

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                valid_q, valid_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                busy_q;
  logic                snap;

  logic [NUM_CH-1:0]      dirty;
  logic [NUM_CH-1:0]      ovw;
  logic [NUM_CH*CH_W-1:0] shadows;
  logic [MAX_CH-1:0]      ovw_ext;
  logic [DROP_W:0]        drop_sum;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    sensor_ch_slot #(.CH_W(CH_W)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .capture_i  (ch_valid[g]),
      .clear_i    (snap),
      .data_i     (ch_data[g*CH_W +: CH_W]),
      .shadow_o   (shadows[g*CH_W +: CH_W]),
      .dirty_o    (dirty[g]),
      .overwrite_o(ovw[g])
    );
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    frame_d = frame_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    snap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|dirty) begin
          snap    = 1'b1;
          frame_d = {seq_q, dirty, shadows};
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && frame_ready) begin
          valid_d = 1'b0;
          seq_d   = seq_q + SEQ_W'(1);
          if (HOLDOFF == 0) begin
            state_d = IDLE;
          end else begin
            hold_d  = HW'(HOLDOFF);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Leaving at a count of 1 gives exactly HOLDOFF cycles in HOLD.
        hold_d = hold_q - HW'(1);
        if (hold_q <= HW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating add of this cycle's overwrite popcount.
  always_comb begin
    ovw_ext             = '0;
    ovw_ext[NUM_CH-1:0] = ovw;
    drop_sum            = {1'b0, drop_q} + (DROP_W+1)'(popcount8(ovw_ext));
    drop_d              = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seq_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign drop_cnt    = drop_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sensor_frame_agg.sv
// Bench for sensor_frame_agg: instance A with HOLDOFF=100, instance B with
// HOLDOFF=0. A cycle-level behavioural model per instance is checked every
// cycle; directed sequences add hand-computed literal expectations.
module tb_sensor_frame_agg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cva = '0, cvb = '0;
  logic [47:0] da = '0, db = '0;
  logic        rdya = 1'b0, rdyb = 1'b0;
  logic [57:0] fda, fdb;
  logic        fva, fvb, busya, busyb;
  logic [15:0] dropa, dropb;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sensor_frame_agg #(.NUM_CH(2), .CH_W(24), .SEQ_W(8), .HOLDOFF(100), .DROP_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .ch_data(da), .ch_valid(cva),
    .frame_data(fda), .frame_valid(fva), .frame_ready(rdya),
    .drop_cnt(dropa), .busy(busya)
  );

  sensor_frame_agg #(.NUM_CH(2), .CH_W(24), .SEQ_W(8), .HOLDOFF(0), .DROP_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .ch_data(db), .ch_valid(cvb),
    .frame_data(fdb), .frame_valid(fvb), .frame_ready(rdyb),
    .drop_cnt(dropb), .busy(busyb)
  );

  // ---------------- behavioural model ----------------
  // A frame is pending while fv is set; hold counts remaining idle cycles.
  typedef struct packed {
    logic [1:0][23:0] sh;
    logic [1:0]       dirty;
    logic [7:0]       seq;
    logic [57:0]      fd;
    logic             fv;
    logic [31:0]      hold;
    logic [15:0]      drop;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, logic [1:0] cv, logic [47:0] d, logic rdy, int holdoff);
    mdl_t n;
    bit   take;
    int   dr;
    n    = m;
    take = !m.fv && (m.hold == 0) && (m.dirty != 2'b00);
    dr   = int'(m.drop);
    for (int i = 0; i < 2; i++) begin
      if (cv[i]) begin
        n.sh[i] = d[i*24 +: 24];
        if (m.dirty[i] && !take) dr++;
      end
    end
    n.drop = (dr > 65535) ? 16'hFFFF : 16'(dr);
    if (take) begin
      n.fd    = {m.seq, m.dirty, m.sh[1], m.sh[0]};
      n.fv    = 1'b1;
      n.dirty = cv;
    end else begin
      n.dirty = m.dirty | cv;
      if (m.fv && rdy) begin
        n.fv   = 1'b0;
        n.seq  = m.seq + 8'd1;
        n.hold = 32'(holdoff);
      end else if (m.hold > 0) begin
        n.hold = m.hold - 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= step(ma, cva, da, rdya, 100);
      mb <= step(mb, cvb, db, rdyb, 0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("A.frame_valid", 64'(fva),   64'(ma.fv));
      chk("A.frame_data",  64'(fda),   64'(ma.fd));
      chk("A.drop_cnt",    64'(dropa), 64'(ma.drop));
      chk("A.busy",        64'(busya), 64'(ma.fv || (ma.hold > 0)));
      chk("B.frame_valid", 64'(fvb),   64'(mb.fv));
      chk("B.frame_data",  64'(fdb),   64'(mb.fd));
      chk("B.drop_cnt",    64'(dropb), 64'(mb.drop));
      chk("B.busy",        64'(busyb), 64'(mb.fv || (mb.hold > 0)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic nx();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fva();
    int n = 0;
    while (!fva && n < 300) begin nx(); n++; end
    chk("A.wait_frame", 64'(fva), 64'd1);
  endtask

  initial begin
    int bc, frames, n;
    bit seen;
    logic [7:0] prev, last_seq;
    bit first;

    #12;
    chk("rst.frame_valid", 64'(fva),   64'd0);
    chk("rst.frame_data",  64'(fda),   64'd0);
    chk("rst.drop_cnt",    64'(dropa), 64'd0);
    chk("rst.busy",        64'(busya), 64'd0);
    nx();
    rst_n = 1'b1;
    nx(); nx();

    // 1: single ch0 update, latency 2, 101 busy cycles (1 SEND + 100 HOLD)
    rdya = 1'b1;
    cva = 2'b01; da[23:0] = 24'h123456;
    nx();
    cva = 2'b00;
    chk("t1.no_frame_t1", 64'(fva), 64'd0);
    nx();
    chk("t1.frame_valid_t2", 64'(fva), 64'd1);
    chk("t1.frame", 64'(fda), 64'({8'h00, 2'b01, 24'h000000, 24'h123456}));
    bc = 0;
    while (busya && bc < 300) begin bc++; nx(); end
    chk("t1.busy_cycles", 64'(bc), 64'd101);

    // 2: simultaneous strobes give one frame with both values, seq=1
    cva = 2'b11; da = {24'h555555, 24'hAAAAAA};
    nx();
    cva = 2'b00;
    wait_fva();
    chk("t2.frame", 64'(fda), 64'({8'h01, 2'b11, 24'h555555, 24'hAAAAAA}));
    repeat (110) nx();
    chk("t2.no_second_frame", 64'(fva), 64'd0);
    chk("t2.idle", 64'(busya), 64'd0);

    // 3: stalled consumer, three ch0 updates during SEND
    rdya = 1'b0;
    cva = 2'b01; da[23:0] = 24'h000111;
    nx();
    cva = 2'b00;
    wait_fva();
    for (int i = 0; i < 50; i++) begin
      cva = (i == 5 || i == 15 || i == 25) ? 2'b01 : 2'b00;
      da[23:0] = (i == 5) ? 24'h000A01 : (i == 15) ? 24'h000A02 : 24'h000A03;
      nx();
      chk("t3.stable", 64'(fda), 64'({8'h02, 2'b01, 24'h555555, 24'h000111}));
    end
    cva = 2'b00;
    chk("t3.drop_cnt", 64'(dropa), 64'd2);
    rdya = 1'b1;
    nx();
    chk("t3.accepted", 64'(fva), 64'd0);
    wait_fva();
    chk("t3.next_frame", 64'(fda), 64'({8'h03, 2'b01, 24'h555555, 24'h000A03}));

    // 6: reset while a frame is pending
    nx();
    rdya = 1'b0;
    repeat (110) nx();
    cva = 2'b10; da[47:24] = 24'h777777;
    nx();
    cva = 2'b00;
    wait_fva();
    #1 rst_n = 1'b0;
    #1;
    chk("t6.frame_valid", 64'(fva),   64'd0);
    chk("t6.busy",        64'(busya), 64'd0);
    chk("t6.drop_cnt",    64'(dropa), 64'd0);
    chk("t6.frame_data",  64'(fda),   64'd0);
    nx(); nx();
    rst_n = 1'b1;
    rdya = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nx();
      chk("t6.quiet", 64'(fva), 64'd0);
    end
    cva = 2'b01; da[23:0] = 24'h0000BB;
    nx();
    cva = 2'b00;
    wait_fva();
    chk("t6.seq_restart", 64'(fda), 64'({8'h00, 2'b01, 24'h000000, 24'h0000BB}));

    // 4: HOLDOFF=0, ch1 strobed 10 consecutive cycles
    rdyb = 1'b1;
    frames = 0;
    last_seq = 8'hxx;
    for (int i = 0; i < 20; i++) begin
      cvb = (i < 10) ? 2'b10 : 2'b00;
      db  = {24'(i + 1), 24'h000000};
      nx();
      if (fvb) begin frames++; last_seq = fdb[57:50]; end
    end
    cvb = 2'b00;
    chk("t4.frames", 64'(frames), 64'd6);
    chk("t4.last_seq", 64'(last_seq), 64'd5);
    chk("t4.drop_cnt", 64'(dropb), 64'd4);

    // 5a: seq wrap 0xFF -> 0x00
    seen = 1'b0; first = 1'b1; prev = 8'h00; n = 0;
    cvb = 2'b01;
    while (!seen && n < 1200) begin
      db[23:0] = 24'(n);
      nx();
      n++;
      if (fvb) begin
        if (!first && prev == 8'hFF && fdb[57:50] == 8'h00) seen = 1'b1;
        prev  = fdb[57:50];
        first = 1'b0;
      end
    end
    cvb = 2'b00;
    chk("t5.seq_wrap", 64'(seen), 64'd1);

    // 5b: drop_cnt saturation with a stalled consumer
    rdyb = 1'b0;
    cvb  = 2'b11;
    n = 0;
    while (dropb != 16'hFFFF && n < 40000) begin nx(); n++; end
    repeat (4) nx();
    cvb = 2'b00;
    chk("t5.drop_sat", 64'(dropb), 64'hFFFF);
    nx();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
